seven_seg_scan_ctrl: RTL and testbench

- Time-multiplexed scan controller for a common-anode multi-digit seven-segment display.
- Holds a BCD value in a double-buffered register and enables one digit at a time, with a guard (blank) interval between digits.
- Decodes each digit to active-low segments, with optional leading-zero blanking.
- Sits between the system value producer (valid/ready load port) and the board display pins.

---
 rtl/seven_seg_scan_ctrl_if.sv | 16 +
 rtl/seven_seg_scan_ctrl.sv | 160 ++++++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/seven_seg_scan_ctrl_if.sv
// Load port between the value producer and the seven-segment scan controller.
//   load_valid : producer offers a new display value
//   load_ready : controller can accept a value
//   value_in   : BCD nibbles, nibble i is digit i (digit 0 least significant)
//   dp_in      : decimal-point enables, 1 = lit
interface seven_seg_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      load_valid;
    logic                      load_ready;
    logic [4*NUM_DIGITS-1:0]   value_in;
    logic [NUM_DIGITS-1:0]     dp_in;

    modport master (output load_valid, output value_in, output dp_in, input load_ready);
    modport slave  (input load_valid, input value_in, input dp_in, output load_ready);
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode seven-segment display.
// A loaded value sits in a shadow register until the end of the current frame,
// so a frame is never drawn with a mix of old and new digits.
//   clk, rst_n : system clock (rising edge), asynchronous active-low reset
//   load_if    : valid/ready load port (value_in, dp_in)
//   blank_lz   : live leading-zero blanking enable
//   an_n       : digit anode enables, active low
//   seg_n      : segments a..g on bits 0..6, active low
//   dp_n       : decimal point, active low
//
// Scan state (derived from the slot counter):
//   state   | meaning
//   S_GUARD | start of a slot, all anodes off to avoid ghosting
//   S_ON    | anode idx driven with its decoded segments
module seven_seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int GUARD_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    seven_seg_scan_ctrl_if.slave   load_if,
    input  logic                   blank_lz,
    output logic [NUM_DIGITS-1:0]  an_n,
    output logic [6:0]             seg_n,
    output logic                   dp_n
);
    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] GUARD_END = CNT_W'(GUARD_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic {S_GUARD, S_ON} scan_state_e;

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] shadow_val_q, shadow_val_d;
    logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic [4*NUM_DIGITS-1:0] disp_val_q, disp_val_d;
    logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;
    logic                    pending_q, pending_d;
    logic                    load_ready_q, load_ready_d;
    logic [NUM_DIGITS-1:0]   an_n_q, an_n_d;
    logic [6:0]              seg_n_q, seg_n_d;
    logic                    dp_n_q, dp_n_d;

    scan_state_e             scan_state;
    logic                    slot_end;
    logic                    frame_end;
    logic                    transfer;
    logic                    zero_run;
    logic [NUM_DIGITS-1:0]   lz_blank;
    logic [3:0]              cur_nib;

    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    always_comb begin
        slot_end  = (cnt_q == CNT_LAST);
        frame_end = slot_end && (idx_q == IDX_LAST);
        transfer  = load_if.load_valid && load_ready_q;
        scan_state = (GUARD_CYCLES > 0 && cnt_q < GUARD_END) ? S_GUARD : S_ON;

        cnt_d        = slot_end ? '0 : cnt_q + 1'b1;
        idx_d        = idx_q;
        shadow_val_d = shadow_val_q;
        shadow_dp_d  = shadow_dp_q;
        disp_val_d   = disp_val_q;
        disp_dp_d    = disp_dp_q;
        pending_d    = pending_q;

        if (slot_end) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        // The copy looks at pending_q, so a transfer landing on the frame-end
        // cycle is held in the shadow until the following frame end.
        if (frame_end && pending_q) begin
            disp_val_d = shadow_val_q;
            disp_dp_d  = shadow_dp_q;
            pending_d  = 1'b0;
        end
        // load_ready_q is low whenever pending_q is set, so a transfer never
        // coincides with the copy above.
        if (transfer) begin
            shadow_val_d = load_if.value_in;
            shadow_dp_d  = load_if.dp_in;
            pending_d    = 1'b1;
        end
        load_ready_d = ~pending_d;

        // A digit is a leading zero when it and every digit above it are zero.
        zero_run = 1'b1;
        lz_blank = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run    = zero_run && (disp_val_q[4*i +: 4] == 4'd0);
            lz_blank[i] = zero_run && (i != 0);
        end

        cur_nib = disp_val_q[{idx_q, 2'b00} +: 4];

        an_n_d  = '1;
        seg_n_d = 7'h7F;
        dp_n_d  = 1'b1;
        if (scan_state == S_ON) begin
            an_n_d  = ~(NUM_DIGITS'(1) << idx_q);
            seg_n_d = (blank_lz && lz_blank[idx_q]) ? 7'h7F : decode(cur_nib);
            dp_n_d  = ~disp_dp_q[idx_q];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            shadow_val_q <= '0;
            shadow_dp_q  <= '0;
            disp_val_q   <= '0;
            disp_dp_q    <= '0;
            pending_q    <= 1'b0;
            load_ready_q <= 1'b1;
            an_n_q       <= '1;
            seg_n_q      <= 7'h7F;
            dp_n_q       <= 1'b1;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shadow_val_q <= shadow_val_d;
            shadow_dp_q  <= shadow_dp_d;
            disp_val_q   <= disp_val_d;
            disp_dp_q    <= disp_dp_d;
            pending_q    <= pending_d;
            load_ready_q <= load_ready_d;
            an_n_q       <= an_n_d;
            seg_n_q      <= seg_n_d;
            dp_n_q       <= dp_n_d;
        end
    end

    assign load_if.load_ready = load_ready_q;
    assign an_n  = an_n_q;
    assign seg_n = seg_n_q;
    assign dp_n  = dp_n_q;
endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl (4 digits, 8-cycle slots, 2-cycle guard).
// Expected digit slots are queued as stimulus is issued; a monitor checks each
// slot when its anode first turns on, including the cycle it happens on.
module tb_seven_seg_scan_ctrl;
    localparam int ND = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          blank_lz;
    logic [ND-1:0] an_n;
    logic [6:0]    seg_n;
    logic          dp_n;

    seven_seg_scan_ctrl_if #(.NUM_DIGITS(ND)) lif();

    seven_seg_scan_ctrl #(
        .NUM_DIGITS(ND),
        .REFRESH_DIV(8),
        .GUARD_CYCLES(2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_if  (lif),
        .blank_lz (blank_lz),
        .an_n     (an_n),
        .seg_n    (seg_n),
        .dp_n     (dp_n)
    );

    always #5 clk = ~clk;

    // Edges since reset release; after the edge that handles slot time t, cyc = t+1.
    int cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    typedef struct {
        int         t;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       rdy;
    } exp_s;

    exp_s exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(string name, int act, int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (time %0t)", name, act, req, $time);
    endtask

    task automatic push(int t, logic [3:0] an, logic [6:0] seg, logic dp, logic rdy);
        exp_s e;
        e.t = t; e.an = an; e.seg = seg; e.dp = dp; e.rdy = rdy;
        exp_q.push_back(e);
    endtask

    // Next edge will handle slot time "target"; inputs change 1 unit after an edge.
    task automatic goto(int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load(logic [15:0] v, logic [3:0] dp);
        lif.load_valid = 1'b1;
        lif.value_in   = v;
        lif.dp_in      = dp;
    endtask

    task automatic zero_frame(int base);
        push(base + 2,  4'hE, 7'h40, 1'b1, 1'b1);
        push(base + 10, 4'hD, 7'h40, 1'b1, 1'b1);
        push(base + 18, 4'hB, 7'h40, 1'b1, 1'b1);
        push(base + 26, 4'h7, 7'h40, 1'b1, 1'b1);
    endtask

    // Monitor: a slot is presented when the anodes leave the all-off guard.
    logic [3:0] prev_an = 4'hF;
    always @(negedge clk) begin
        exp_s e;
        if (!rst_n) begin
            prev_an = 4'hF;
        end else begin
            if (an_n != 4'hF && prev_an == 4'hF && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check($sformatf("slot%0d_time", e.t), cyc - 1, e.t);
                check($sformatf("slot%0d_an", e.t), an_n, e.an);
                check($sformatf("slot%0d_seg", e.t), seg_n, e.seg);
                check($sformatf("slot%0d_dp", e.t), dp_n, e.dp);
                check($sformatf("slot%0d_ready", e.t), lif.load_ready, e.rdy);
            end
            prev_an = an_n;
        end
    end

    initial begin
        rst_n          = 1'b1;
        blank_lz       = 1'b0;
        lif.load_valid = 1'b0;
        lif.value_in   = '0;
        lif.dp_in      = '0;
        #1 rst_n = 1'b0;
        #2;
        check("rst_an", an_n, 4'hF);
        check("rst_seg", seg_n, 7'h7F);
        check("rst_dp", dp_n, 1'b1);
        check("rst_ready", lif.load_ready, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Idle: zeros on every digit.
        zero_frame(0);
        goto(32);
        push(34, 4'hE, 7'h40, 1'b1, 1'b1);
        push(42, 4'hD, 7'h40, 1'b1, 1'b1);
        push(50, 4'hB, 7'h40, 1'b1, 1'b0);
        push(58, 4'h7, 7'h40, 1'b1, 1'b0);
        goto(44); load(16'h1234, 4'b0010);
        goto(45); lif.load_valid = 1'b0;

        // 1234 with dp on digit1; load 0050 and enable blanking mid-frame.
        goto(64);
        push(66, 4'hE, 7'h19, 1'b1, 1'b1);
        push(74, 4'hD, 7'h30, 1'b0, 1'b0);
        push(82, 4'hB, 7'h24, 1'b1, 1'b0);
        push(90, 4'h7, 7'h79, 1'b1, 1'b0);
        goto(70); load(16'h0050, 4'b0000); blank_lz = 1'b1;
        goto(71); lif.load_valid = 1'b0;

        // 0050 blanked above digit1; load 0000.
        goto(96);
        push(98,  4'hE, 7'h40, 1'b1, 1'b1);
        push(106, 4'hD, 7'h12, 1'b1, 1'b0);
        push(114, 4'hB, 7'h7F, 1'b1, 1'b0);
        push(122, 4'h7, 7'h7F, 1'b1, 1'b0);
        goto(100); load(16'h0000, 4'b0000);
        goto(101); lif.load_valid = 1'b0;

        // 0000 blanked: only digit0 lit; load 00AF.
        goto(128);
        push(130, 4'hE, 7'h40, 1'b1, 1'b1);
        push(138, 4'hD, 7'h7F, 1'b1, 1'b0);
        push(146, 4'hB, 7'h7F, 1'b1, 1'b0);
        push(154, 4'h7, 7'h7F, 1'b1, 1'b0);
        goto(132); load(16'h00AF, 4'b0000);
        goto(133); lif.load_valid = 1'b0;

        // 00AF without blanking: A and F are blank codes.
        goto(160);
        blank_lz = 1'b0;
        push(162, 4'hE, 7'h7F, 1'b1, 1'b1);
        push(170, 4'hD, 7'h7F, 1'b1, 1'b1);
        push(178, 4'hB, 7'h40, 1'b1, 1'b1);
        push(186, 4'h7, 7'h40, 1'b1, 1'b1);
        goto(191); load(16'h9876, 4'b1000);   // transfer on the frame-end cycle

        // Display holds 00AF a full frame; a second offer is refused.
        goto(192);
        lif.load_valid = 1'b0;
        push(194, 4'hE, 7'h7F, 1'b1, 1'b0);
        push(202, 4'hD, 7'h7F, 1'b1, 1'b0);
        push(210, 4'hB, 7'h40, 1'b1, 1'b0);
        push(218, 4'h7, 7'h40, 1'b1, 1'b0);
        goto(200); load(16'h5555, 4'b1111);
        goto(210); lif.load_valid = 1'b0;

        // 9876 arrives; load 4321 then reset before it can be shown.
        goto(224);
        push(226, 4'hE, 7'h02, 1'b1, 1'b1);
        push(234, 4'hD, 7'h78, 1'b1, 1'b0);
        goto(230); load(16'h4321, 4'b0001);
        goto(231); lif.load_valid = 1'b0;
        goto(236);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_an", an_n, 4'hF);
        check("midrst_seg", seg_n, 7'h7F);
        check("midrst_dp", dp_n, 1'b1);
        check("midrst_ready", lif.load_ready, 1'b1);
        check("midrst_queue", exp_q.size(), 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        zero_frame(0);
        goto(32);
        zero_frame(32);
        goto(64);
        check("final_queue", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
